hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter: MC_LATENCY, 4, total EX-stage occupancy in cycles of a multicycle ALU op; legal range 2..16.
REQ-002 clock  in  1  pipeline clock, all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-005 ex_rs, ex_rt  in  5 each  source register numbers held in ID/EX.
REQ-006 ex_rd  in  5;  ex_regwrite  in  1;  ex_memread  in  1  EX-stage destination, write enable, load flag.
REQ-007 mem_rd  in  5;  mem_regwrite  in  1  EX/MEM destination and write enable.
REQ-008 wb_rd  in  5;  wb_regwrite  in  1  MEM/WB destination and write enable.
REQ-009 mc_start  in  1  multicycle ALU op present in EX this cycle.
REQ-010 branch_taken  in  1  branch in EX resolved taken this cycle.
REQ-011 pc_stall, if_id_stall  out  1 each  hold PC and IF/ID registers.
REQ-012 id_ex_bubble  out  1  load NOP control into ID/EX at next edge.
REQ-013 if_id_flush  out  1  load NOP instruction into IF/ID at next edge.
REQ-014 ex_hold  out  1  hold ID/EX; ex_mem_bubble out 1 load NOP control into EX/MEM.
REQ-015 fwd_d1_ctrl, fwd_d2_ctrl  out  2 each  ALU operand mux select: 0 = ID/EX data, 1 = EX/MEM ALU result, 2 = write-back value; 3 never driven.
REQ-016 busy  out  1  high in MC_BUSY; stall_count  out  16  registered count of stalled cycles for the UI.

Function
REQ-017 State machine SHALL have two states, RUN and MC_BUSY, plus a 4-bit down counter cnt.
REQ-018 Forwarding SHALL be combinational: fwd_d1_ctrl = 1 if mem_regwrite and mem_rd != 0 and mem_rd == ex_rs; else 2 if wb_regwrite and wb_rd != 0 and wb_rd == ex_rs; else 0; fwd_d2_ctrl identical using ex_rt.
REQ-019 EX/MEM match SHALL take priority over MEM/WB match; register 0 SHALL never forward.
REQ-020 Load-use hazard lu = RUN and ex_memread and ex_regwrite and ex_rd != 0 and (ex_rd == id_rs or ex_rd == id_rt).
REQ-021 On lu with branch_taken low: pc_stall = if_id_stall = id_ex_bubble = 1 for exactly that cycle; combinational, no state change.
REQ-022 On branch_taken in RUN: if_id_flush = id_ex_bubble = 1, pc_stall = if_id_stall = 0; branch SHALL win over lu and mc_start.
REQ-023 In RUN, mc_start with branch_taken low: pc_stall = if_id_stall = ex_hold = ex_mem_bubble = 1 that cycle; next state MC_BUSY, cnt <= MC_LATENCY-2.
REQ-024 In MC_BUSY with cnt != 0: pc_stall = if_id_stall = ex_hold = ex_mem_bubble = 1; cnt decrements.
REQ-025 In MC_BUSY with cnt == 0: all stall/hold/bubble outputs 0 (result advances); next state RUN.
REQ-026 Multicycle op SHALL occupy EX exactly MC_LATENCY cycles, with stalls asserted in the first MC_LATENCY-1 of them.
REQ-027 In MC_BUSY, branch_taken, mc_start and lu SHALL be ignored; forwarding remains active.
REQ-028 busy = 1 iff state == MC_BUSY.
REQ-029 stall_count SHALL increment by 1 at each edge where pc_stall = 1, saturating at 0xFFFF (no wrap).
REQ-030 Outputs not asserted by REQ-021..REQ-025 SHALL be 0.

Reset
REQ-031 reset high at an edge SHALL set state RUN, cnt 0, stall_count 0, including mid-MC_BUSY.
REQ-032 While reset is high, pc_stall, if_id_stall, id_ex_bubble, if_id_flush, ex_hold, ex_mem_bubble and busy SHALL be 0; fwd_*_ctrl SHALL remain combinational.

Verification
REQ-033 ex_rs=5, mem_rd=5, mem_regwrite=1, wb_rd=5, wb_regwrite=1 -> fwd_d1_ctrl=1; then mem_regwrite=0 -> fwd_d1_ctrl=2; then all rd=0 -> 0.
REQ-034 ex_memread=1, ex_regwrite=1, ex_rd=8, id_rt=8 -> one cycle pc_stall=if_id_stall=id_ex_bubble=1; stall_count goes 0 -> 1.
REQ-035 Same load-use plus branch_taken=1 -> if_id_flush=1, id_ex_bubble=1, pc_stall=0, stall_count unchanged.
REQ-036 MC_LATENCY=4, mc_start pulse in RUN -> ex_hold high 3 cycles, low 4th, busy high cycles 2-4, stall_count = 3.
REQ-037 mc_start, then reset on 2nd busy cycle -> next cycle state RUN, busy=0, stall_count=0.
REQ-038 Hold pc_stall asserted 65 540 cycles via repeated load-use -> stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-side bundle of hazard controller inputs and controls
interface hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_rd;
    logic        ex_regwrite;
    logic        ex_memread;
    logic [4:0]  mem_rd;
    logic        mem_regwrite;
    logic [4:0]  wb_rd;
    logic        wb_regwrite;
    logic        mc_start;
    logic        branch_taken;

    logic        pc_stall;
    logic        if_id_stall;
    logic        id_ex_bubble;
    logic        if_id_flush;
    logic        ex_hold;
    logic        ex_mem_bubble;
    logic [1:0]  fwd_d1_ctrl;
    logic [1:0]  fwd_d2_ctrl;
    logic        busy;
    logic [15:0] stall_count;

    modport master (
        output id_rs, id_rt, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, wb_rd, wb_regwrite, mc_start, branch_taken,
        input  pc_stall, if_id_stall, id_ex_bubble, if_id_flush, ex_hold,
               ex_mem_bubble, fwd_d1_ctrl, fwd_d2_ctrl, busy, stall_count
    );

    modport slave (
        input  id_rs, id_rt, ex_rs, ex_rt, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, wb_rd, wb_regwrite, mc_start, branch_taken,
        output pc_stall, if_id_stall, id_ex_bubble, if_id_flush, ex_hold,
               ex_mem_bubble, fwd_d1_ctrl, fwd_d2_ctrl, busy, stall_count
    );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, load-use/branch hazards and multicycle EX stall control
module hazard_ctrl #(
    parameter int unsigned MC_LATENCY = 4
) (
    input  logic        clock,
    input  logic        reset,
    hazard_ctrl_if.slave hz
);

    typedef enum logic {RUN, MC_BUSY} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MC_LATENCY - 2);

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic [15:0] stall_count;
    logic        lu;
    logic        pc_stall, if_id_stall, id_ex_bubble, if_id_flush, ex_hold, ex_mem_bubble;

    // The newer producer (EX/MEM) shadows the older one; r0 is hardwired zero and never forwards.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic [4:0] m_rd, input logic m_we,
                                           input logic [4:0] w_rd, input logic w_we);
        if (m_we && (m_rd != 5'd0) && (m_rd == src))
            return 2'd1;
        else if (w_we && (w_rd != 5'd0) && (w_rd == src))
            return 2'd2;
        else
            return 2'd0;
    endfunction

    assign hz.fwd_d1_ctrl = fwd_sel(hz.ex_rs, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite);
    assign hz.fwd_d2_ctrl = fwd_sel(hz.ex_rt, hz.mem_rd, hz.mem_regwrite, hz.wb_rd, hz.wb_regwrite);

    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        pc_stall      = 1'b0;
        if_id_stall   = 1'b0;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        ex_hold       = 1'b0;
        ex_mem_bubble = 1'b0;
        lu = (state == RUN) && hz.ex_memread && hz.ex_regwrite && (hz.ex_rd != 5'd0) &&
             ((hz.ex_rd == hz.id_rs) || (hz.ex_rd == hz.id_rt));

        if (!reset) begin
            case (state)
                RUN: begin
                    // A taken branch squashes the younger instructions, so nothing behind it may stall.
                    if (hz.branch_taken) begin
                        if_id_flush  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end else if (hz.mc_start) begin
                        pc_stall      = 1'b1;
                        if_id_stall   = 1'b1;
                        ex_hold       = 1'b1;
                        ex_mem_bubble = 1'b1;
                        state_next    = MC_BUSY;
                        cnt_next      = CNT_LOAD;
                    end else if (lu) begin
                        pc_stall     = 1'b1;
                        if_id_stall  = 1'b1;
                        id_ex_bubble = 1'b1;
                    end
                end
                MC_BUSY: begin
                    if (cnt != 4'd0) begin
                        pc_stall      = 1'b1;
                        if_id_stall   = 1'b1;
                        ex_hold       = 1'b1;
                        ex_mem_bubble = 1'b1;
                        cnt_next      = cnt - 4'd1;
                    end else begin
                        state_next = RUN;
                    end
                end
                default: state_next = RUN;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= 4'd0;
            stall_count <= 16'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (pc_stall && (stall_count != 16'hFFFF))
                stall_count <= stall_count + 16'd1;
        end
    end

    assign hz.pc_stall      = pc_stall;
    assign hz.if_id_stall   = if_id_stall;
    assign hz.id_ex_bubble  = id_ex_bubble;
    assign hz.if_id_flush   = if_id_flush;
    assign hz.ex_hold       = ex_hold;
    assign hz.ex_mem_bubble = ex_mem_bubble;
    assign hz.busy          = (state == MC_BUSY) && !reset;
    assign hz.stall_count   = stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl
module tb_hazard_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    hazard_ctrl_if hif();

    hazard_ctrl #(.MC_LATENCY(4)) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hif.slave)
    );

    // control word: {pc_stall, if_id_stall, id_ex_bubble, if_id_flush, ex_hold, ex_mem_bubble, busy}
    localparam logic [6:0] C_NONE = 7'b0000000;
    localparam logic [6:0] C_LU   = 7'b1110000;
    localparam logic [6:0] C_BR   = 7'b0011000;
    localparam logic [6:0] C_MC   = 7'b1100110;
    localparam logic [6:0] C_MCB  = 7'b1100111;
    localparam logic [6:0] C_BUSY = 7'b0000001;

    logic [10:0] exp_q[$];
    logic [15:0] cnt_q[$];
    string       name_q[$];
    int          tests = 0;
    int          fails = 0;

    wire [10:0] got_out = {hif.pc_stall, hif.if_id_stall, hif.id_ex_bubble, hif.if_id_flush,
                           hif.ex_hold, hif.ex_mem_bubble, hif.busy, hif.fwd_d1_ctrl, hif.fwd_d2_ctrl};

    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            logic [10:0] e;
            logic [15:0] c;
            string       n;
            e = exp_q.pop_front();
            c = cnt_q.pop_front();
            n = name_q.pop_front();
            tests++;
            if (got_out !== e) begin
                fails++;
                $display("FAIL %s outputs: got %b required %b", n, got_out, e);
            end
            tests++;
            if (hif.stall_count !== c) begin
                fails++;
                $display("FAIL %s stall_count: got %h required %h", n, hif.stall_count, c);
            end
        end
    end

    task automatic clear_inputs();
        hif.id_rs = 5'd0; hif.id_rt = 5'd0; hif.ex_rs = 5'd0; hif.ex_rt = 5'd0;
        hif.ex_rd = 5'd0; hif.ex_regwrite = 1'b0; hif.ex_memread = 1'b0;
        hif.mem_rd = 5'd0; hif.mem_regwrite = 1'b0; hif.wb_rd = 5'd0; hif.wb_regwrite = 1'b0;
        hif.mc_start = 1'b0; hif.branch_taken = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        hif.ex_memread = 1'b1; hif.ex_regwrite = 1'b1;
        hif.ex_rd = rd; hif.id_rs = rs; hif.id_rt = rt;
    endtask

    task automatic step(input string n, input logic [6:0] ctl, input logic [1:0] f1,
                        input logic [1:0] f2, input logic [15:0] c);
        exp_q.push_back({ctl, f1, f2});
        cnt_q.push_back(c);
        name_q.push_back(n);
        @(posedge clock);
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;

        // reset state: stall outputs suppressed, forwarding still live
        hif.mc_start = 1'b1; hif.ex_rs = 5'd5; hif.mem_rd = 5'd5; hif.mem_regwrite = 1'b1;
        set_lu(5'd8, 5'd8, 5'd0);
        step("reset_state", C_NONE, 2'd1, 2'd0, 16'd0);
        reset = 1'b0;

        clear_inputs();
        hif.ex_rs = 5'd5; hif.mem_rd = 5'd5; hif.mem_regwrite = 1'b1;
        hif.wb_rd = 5'd5; hif.wb_regwrite = 1'b1;
        step("fwd_mem_prio", C_NONE, 2'd1, 2'd0, 16'd0);
        hif.mem_regwrite = 1'b0;
        step("fwd_wb", C_NONE, 2'd2, 2'd0, 16'd0);
        hif.ex_rs = 5'd0; hif.mem_rd = 5'd0; hif.wb_rd = 5'd0;
        hif.mem_regwrite = 1'b1; hif.wb_regwrite = 1'b1;
        step("fwd_r0", C_NONE, 2'd0, 2'd0, 16'd0);
        hif.ex_rs = 5'd3; hif.ex_rt = 5'd9; hif.mem_rd = 5'd9; hif.wb_rd = 5'd3;
        step("fwd_both", C_NONE, 2'd2, 2'd1, 16'd0);
        hif.ex_rs = 5'd9;
        step("fwd_same", C_NONE, 2'd1, 2'd1, 16'd0);

        clear_inputs();
        set_lu(5'd8, 5'd0, 5'd8);
        step("lu_rt", C_LU, 2'd0, 2'd0, 16'd0);
        clear_inputs();
        step("lu_after", C_NONE, 2'd0, 2'd0, 16'd1);
        set_lu(5'd0, 5'd0, 5'd0);
        step("lu_rd0", C_NONE, 2'd0, 2'd0, 16'd1);
        set_lu(5'd8, 5'd8, 5'd0);
        hif.ex_regwrite = 1'b0;
        step("lu_no_we", C_NONE, 2'd0, 2'd0, 16'd1);

        set_lu(5'd8, 5'd0, 5'd8);
        hif.branch_taken = 1'b1;
        step("br_over_lu", C_BR, 2'd0, 2'd0, 16'd1);
        clear_inputs();
        step("br_after", C_NONE, 2'd0, 2'd0, 16'd1);
        hif.branch_taken = 1'b1; hif.mc_start = 1'b1;
        step("br_over_mc", C_BR, 2'd0, 2'd0, 16'd1);
        clear_inputs();
        step("br_mc_stays_run", C_NONE, 2'd0, 2'd0, 16'd1);

        reset = 1'b1;
        step("reset_mid", C_NONE, 2'd0, 2'd0, 16'd1);
        reset = 1'b0;

        hif.mc_start = 1'b1;
        step("mc_c1", C_MC, 2'd0, 2'd0, 16'd0);
        clear_inputs();
        hif.branch_taken = 1'b1;
        step("mc_c2_ign_br", C_MCB, 2'd0, 2'd0, 16'd1);
        clear_inputs();
        set_lu(5'd8, 5'd8, 5'd0);
        hif.mc_start = 1'b1; hif.ex_rs = 5'd5; hif.mem_rd = 5'd5; hif.mem_regwrite = 1'b1;
        step("mc_c3_ign_lu", C_MCB, 2'd1, 2'd0, 16'd2);
        clear_inputs();
        step("mc_c4_release", C_BUSY, 2'd0, 2'd0, 16'd3);
        step("mc_c5_run", C_NONE, 2'd0, 2'd0, 16'd3);

        hif.mc_start = 1'b1;
        step("mc2_c1", C_MC, 2'd0, 2'd0, 16'd3);
        clear_inputs();
        step("mc2_c2", C_MCB, 2'd0, 2'd0, 16'd4);
        reset = 1'b1;
        hif.ex_rt = 5'd4; hif.wb_rd = 5'd4; hif.wb_regwrite = 1'b1;
        step("mc2_reset", C_NONE, 2'd0, 2'd2, 16'd5);
        reset = 1'b0;
        clear_inputs();
        step("mc2_after_reset", C_NONE, 2'd0, 2'd0, 16'd0);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        set_lu(5'd12, 5'd12, 5'd0);
        for (int i = 0; i < 65540; i++) tick();
        step("sat_lu", C_LU, 2'd0, 2'd0, 16'hFFFF);
        clear_inputs();
        step("sat_hold", C_NONE, 2'd0, 2'd0, 16'hFFFF);
        reset = 1'b1;
        step("sat_reset", C_NONE, 2'd0, 2'd0, 16'hFFFF);
        reset = 1'b0;
        step("sat_cleared", C_NONE, 2'd0, 2'd0, 16'd0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clock);
        if (exp_q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d entries left, required 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
